// File: rtl/accum_sequencer.sv
// accum_sequencer: accepts a batch of NUM_OPS 4-bit operands over a valid/ready
// handshake, sums them through a 4-bit ripple adder into a running total, and
// presents the modulo-16 total plus a sticky carry-out flag on an output
// valid/ready port.
module accum_sequencer #(
  parameter int NUM_OPS = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sum,
  output logic       out_ovf,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  // Gate-level 4-bit ripple adder; bit 4 of the result is the carry out.
  function automatic logic [4:0] ripple_add4(input logic [3:0] x, input logic [3:0] y);
    logic [4:0] c;
    logic [3:0] s;
    c[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    return {c[4], s};
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       add_sum;
  logic             add_cout;

  assign {add_cout, add_sum} = ripple_add4(acc_q, in_data);
  assign cnt_inc             = cnt_q + ONE_CNT;

  assign out_sum = acc_q;
  assign out_ovf = ovf_q;

  // State, running total, overflow and operand count registers; reset wins over any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 4'd0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, datapath update and handshake outputs; in_ready depends on state only.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // First operand loads the total directly; no addition, so no carry.
          acc_d   = in_data;
          ovf_d   = 1'b0;
          cnt_d   = ONE_CNT;
          state_d = (NUM_OPS == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_cout;
          cnt_d = cnt_inc;
          if (cnt_inc == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = 4'd0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
